rvc_asap_5pl_vga_fill_ctrl: RTL and testbench
=============================================

Name: rvc_asap_5pl_vga_fill_ctrl

Overview:
- Hardware fill engine and port-A arbiter for the VGA frame memory.
- Sits between the core's VGA-memory access signals and port A of the VGA memory.
- Core accesses always pass through. A programmed fill writes a 32-bit pattern into a range of frame words using only cycles where the core is not accessing VGA memory.
- Read data (q) goes from memory to core directly; this block does not touch it.

Parameters:
- VGA_WORDS, 9600, frame size in 32-bit words (120 rows x 80 words).
- ROW_WORDS, 80, words per frame row; used by the optional rectangle mode.
- ADDR_W, 14, width of word-index registers.

Ports:
- CLK_50  in  1  clock
- Reset  in  1  synchronous, active-high reset
- core_data  in  32  core write data
- core_address  in  32  core byte address
- core_byteena  in  4  core byte enables
- core_wren  in  1  core write request
- core_rden  in  1  core read request
- cfg_wr  in  1  config register write strobe
- cfg_addr  in  3  config register select
- cfg_wdata  in  32  config write data
- mem_data  out  32  to VGA memory data_a
- mem_address  out  32  to VGA memory (memory uses [31:2])
- mem_byteena  out  4  to VGA memory byteena_a
- mem_wren  out  1  to VGA memory wren_a
- mem_rden  out  1  to VGA memory rden_a
- busy  out  1  fill in progress
- done_pulse  out  1  one-cycle pulse when a fill completes or is aborted
- cur_idx  out  ADDR_W  next word index the engine will write

Behaviour:
- One clock, CLK_50. Reset is synchronous and active-high; all state updates on the rising edge.
- Config registers:
  - 0 START: word index, [ADDR_W-1:0]
  - 1 COUNT: word count, [ADDR_W-1:0]
  - 2 PATTERN: 32-bit fill value
  - 3 CMD: bit0 start, bit1 abort (self-clearing, not stored)
  - 4 WIDTH: only with the optional feature
- Writes to START, COUNT, PATTERN and WIDTH are ignored while busy=1. CMD is always accepted.
- State machine:
  - IDLE, on start: if COUNT==0, stay IDLE and pulse done_pulse in the next cycle. Otherwise load idx=START, remaining=COUNT and go to FILL; busy=1 from the next cycle.
  - FILL: on each cycle with core_wren=0 and core_rden=0, the engine owns port A. It drives mem_wren=1, mem_byteena=4'hF, mem_data=PATTERN, mem_address={idx,2'b00} zero-extended to 32 bits. Then idx advances and remaining decrements.
  - FILL: on cycles with a core access, mux passes the core signals unchanged and engine state holds (core has strict priority).
  - FILL, after the write with remaining==1: go to DONE.
  - DONE: one cycle, done_pulse=1, then IDLE.
- Index wrap: idx==VGA_WORDS-1 advances to 0. A START value >= VGA_WORDS is reduced modulo VGA_WORDS when loaded.
- Abort in FILL: the write in the same cycle is suppressed; go to DONE. Abort and start in the same cycle: abort wins, start ignored. Start while busy: ignored.
- Mux is combinational: 0-cycle latency from core inputs to mem outputs. The engine adds no delay to core accesses.
- Outside FILL, mem_* = core_*.
- Reset, including mid-fill: state IDLE; busy=0; done_pulse=0; cur_idx=0; START=0; COUNT=0; PATTERN=0; WIDTH=0. Mem outputs follow the core inputs.
- Throughput: one word per free cycle. A fill of N words with no core traffic takes N cycles in FILL plus 1 cycle in DONE.

Optional Feature:
- Macro: VGA_FILL_RECT_EN.
- When defined, register 4 WIDTH (1..ROW_WORDS) is added, along with a column counter. After WIDTH consecutive words, idx advances by ROW_WORDS-WIDTH+1 (the same column in the next row) and the column counter resets. COUNT then means the total number of words written (width x height). WIDTH==0 is treated as ROW_WORDS.
- When not defined, writes to cfg_addr 4 are ignored and fills are linear.

Test Plan:
- START=100, COUNT=3, PATTERN=32'hFFFF_0000, start, no core traffic: mem_wren high for 3 cycles at byte addresses 400, 404, 408; done_pulse on the 4th cycle; busy falls afterwards.
- Same fill with core_wren=1 at address 32'h1000 in the 2nd fill cycle: that cycle passes the core write unchanged; fill words are written at 400, 404, 408 over 4 cycles; done_pulse is delayed one cycle.
- START=9598, COUNT=4: words written at indices 9598, 9599, 0, 1 (byte addresses 38392, 38396, 0, 4).
- COUNT=0, start: no mem_wren from the engine; done_pulse 1 cycle later; busy stays 0.
- Abort asserted on the 2nd fill cycle of COUNT=10: exactly 1 word written, done_pulse the next cycle. Reset asserted mid-fill: busy=0 and cur_idx=0 on the next edge, with no further engine writes.
- VGA_FILL_RECT_EN: START=0, WIDTH=2, COUNT=4: words written at indices 0, 1, 80, 81.

Source files
------------

// File: rtl/rvc_asap_5pl_vga_fill_ctrl.sv
// VGA frame-memory fill engine and port-A arbiter: core accesses always win,
// fills use idle cycles. Optional rectangle fills are enabled by VGA_FILL_RECT_EN.
module rvc_asap_5pl_vga_fill_ctrl #(
  parameter int VGA_WORDS = 9600,
  parameter int ROW_WORDS = 80,
  parameter int ADDR_W    = 14
) (
  input  logic              CLK_50,
  input  logic              Reset,
  input  logic [31:0]       core_data,
  input  logic [31:0]       core_address,
  input  logic [3:0]        core_byteena,
  input  logic              core_wren,
  input  logic              core_rden,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       mem_data,
  output logic [31:0]       mem_address,
  output logic [3:0]        mem_byteena,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic              busy,
  output logic              done_pulse,
  output logic [ADDR_W-1:0] cur_idx
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [ADDR_W:0]   VGA_LIM = (ADDR_W+1)'(VGA_WORDS);
  localparam logic [ADDR_W-1:0] ROW_W   = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] start_q, count_q;
  logic [31:0]       pattern_q;
  logic [ADDR_W-1:0] idx_q, idx_d, rem_q, rem_d, col_q, col_d;
  logic              zdone_q, zdone_d;
  logic [ADDR_W-1:0] weff, idx_step, idx_adv;
  logic              row_end, core_act, cmd_start, cmd_abort, fill_wr;

  // Reduce a value below 2*VGA_WORDS into the frame index range.
  function automatic logic [ADDR_W-1:0] wrap_idx(input logic [ADDR_W:0] v);
    return ADDR_W'((v >= VGA_LIM) ? v - VGA_LIM : v);
  endfunction

  assign core_act  = core_wren | core_rden;
  assign cmd_start = cfg_wr && (cfg_addr == 3'd3) && cfg_wdata[0];
  assign cmd_abort = cfg_wr && (cfg_addr == 3'd3) && cfg_wdata[1];
  assign busy      = (state_q != S_IDLE);
  assign fill_wr   = (state_q == S_FILL) && !core_act && !cmd_abort;

`ifdef VGA_FILL_RECT_EN
  logic [ADDR_W-1:0] width_q;
  assign weff = ((width_q == '0) || (width_q > ROW_W)) ? ROW_W : width_q;
`else
  // A linear fill is a rectangle one full row wide, so the step is always 1.
  assign weff = ROW_W;
`endif

  assign row_end  = (col_q == weff - ONE);
  assign idx_step = row_end ? (ROW_W - weff + ONE) : ONE;
  assign idx_adv  = wrap_idx({1'b0, idx_q} + {1'b0, idx_step});

  always_ff @(posedge CLK_50) begin
    if (Reset) begin
      start_q   <= '0;
      count_q   <= '0;
      pattern_q <= '0;
`ifdef VGA_FILL_RECT_EN
      width_q   <= '0;
`endif
    end else if (cfg_wr && !busy) begin
      case (cfg_addr)
        3'd0: start_q   <= cfg_wdata[ADDR_W-1:0];
        3'd1: count_q   <= cfg_wdata[ADDR_W-1:0];
        3'd2: pattern_q <= cfg_wdata;
`ifdef VGA_FILL_RECT_EN
        3'd4: width_q   <= cfg_wdata[ADDR_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_50) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      col_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      col_q   <= col_d;
      zdone_q <= zdone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    col_d   = col_q;
    zdone_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start && !cmd_abort) begin
          if (count_q == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = S_FILL;
            idx_d   = wrap_idx({1'b0, start_q});
            rem_d   = count_q;
            col_d   = '0;
          end
        end
      end
      S_FILL: begin
        if (cmd_abort) begin
          state_d = S_DONE;
        end else if (!core_act) begin
          idx_d = idx_adv;
          rem_d = rem_q - ONE;
          col_d = row_end ? '0 : col_q + ONE;
          if (rem_q == ONE) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port-A mux: the engine only takes the port on its own write cycles.
  always_comb begin
    mem_data    = core_data;
    mem_address = core_address;
    mem_byteena = core_byteena;
    mem_wren    = core_wren;
    mem_rden    = core_rden;
    if (fill_wr) begin
      mem_data    = pattern_q;
      mem_address = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
      mem_byteena = 4'hF;
      mem_wren    = 1'b1;
      mem_rden    = 1'b0;
    end
  end

  assign done_pulse = (state_q == S_DONE) || zdone_q;
  assign cur_idx    = idx_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_fill_ctrl.sv
// Bench for rvc_asap_5pl_vga_fill_ctrl: directed vector table, hand sequences for
// reset behaviour, and randomized fills checked against an arithmetic model.
module tb_rvc_asap_5pl_vga_fill_ctrl;
  localparam int V = 9600, ROW = 80, AW = 14;

  logic          clk = 1'b0;
  logic          Reset;
  logic [31:0]   core_data, core_address, cfg_wdata;
  logic [3:0]    core_byteena;
  logic          core_wren, core_rden, cfg_wr;
  logic [2:0]    cfg_addr;
  logic [31:0]   mem_data, mem_address;
  logic [3:0]    mem_byteena;
  logic          mem_wren, mem_rden, busy, done_pulse;
  logic [AW-1:0] cur_idx;

  always #5 clk = ~clk;

  rvc_asap_5pl_vga_fill_ctrl #(.VGA_WORDS(V), .ROW_WORDS(ROW), .ADDR_W(AW)) dut (
    .CLK_50(clk), .Reset(Reset),
    .core_data(core_data), .core_address(core_address), .core_byteena(core_byteena),
    .core_wren(core_wren), .core_rden(core_rden),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .mem_data(mem_data), .mem_address(mem_address), .mem_byteena(mem_byteena),
    .mem_wren(mem_wren), .mem_rden(mem_rden),
    .busy(busy), .done_pulse(done_pulse), .cur_idx(cur_idx)
  );

  typedef struct {
    int          st;
    int          cnt;
    logic [31:0] pat;
    logic [63:0] mask;
    int          ic;
    logic [2:0]  ia;
    logic [31:0] id;
    int          nw;
    int          a0, a1, a2, a3;
    int          dn;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  vec_t        tbl[11];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    next();
    cfg_wr = 1'b0;
  endtask

  task automatic set_core(input bit act, input bit rnd);
    core_wren = 1'b0;
    core_rden = 1'b0;
    if (act) begin
      if (rnd) begin
        core_data    = $urandom;
        core_address = $urandom;
        core_byteena = 4'($urandom);
        core_wren    = 1'($urandom_range(0, 1));
        core_rden    = !core_wren;
      end else begin
        core_data    = 32'h0BAD_F00D;
        core_address = 32'h0000_1000;
        core_byteena = 4'h3;
        core_wren    = 1'b1;
      end
    end
  endtask

  // Reference: word n of a fill lands at row n/w, column n%w of a rectangle
  // anchored at START; core cycles are skipped, abort ends the fill.
  function automatic int model(input int st, input int cnt, input logic [63:0] mask,
                               input int ab, input int width);
    int w, n;
    exp_q.delete();
`ifdef VGA_FILL_RECT_EN
    w = (width == 0 || width > ROW) ? ROW : width;
`else
    w = ROW;
`endif
    if (cnt == 0) return 0;
    n = 0;
    for (int c = 0; c < 100000; c++) begin
      if (c == ab) return c + 1;
      if (!(c < 64 && mask[c])) begin
        exp_q.push_back(32'((((st % V) + (n / w) * ROW + (n % w)) % V) * 4));
        n++;
        if (n == cnt) return c + 1;
      end
    end
    return -1;
  endfunction

  task automatic run_fill(input string nm, input int st, input int cnt, input logic [31:0] pat,
                          input logic [63:0] mask, input bit rnd, input int ic,
                          input logic [2:0] ia, input logic [31:0] id, input int width,
                          output int dn);
    bit fin;
    got_q.delete();
    dn = -1;
    cfg_write(3'd0, st);
    cfg_write(3'd1, cnt);
    cfg_write(3'd2, pat);
    cfg_write(3'd4, width);
    cfg_write(3'd3, 32'd1);
    for (int c = 0; c < cnt + 70; c++) begin
      set_core(c < 64 && mask[c], rnd);
      if (c == ic) begin
        cfg_wr = 1'b1; cfg_addr = ia; cfg_wdata = id;
      end
      @(negedge clk);
      if (core_wren || core_rden)
        chk({nm, " pass"}, {mem_data, mem_address, mem_byteena, mem_wren, mem_rden},
            {core_data, core_address, core_byteena, core_wren, core_rden});
      else if (mem_wren) begin
        got_q.push_back(mem_address);
        chk({nm, " wdata"}, {mem_data, mem_byteena}, {pat, 4'hF});
      end
      chk({nm, " busy"}, busy, cnt != 0);
      fin = done_pulse;
      next();
      cfg_wr = 1'b0;
      if (fin) begin
        dn = c;
        break;
      end
    end
    set_core(1'b0, 1'b0);
    if (dn < 0) chk({nm, " timeout"}, 1'b0, 1'b1);
    @(negedge clk);
    chk({nm, " after"}, {busy, done_pulse}, 2'b00);
    next();
  endtask

  task automatic compare(input string nm, input int dn, input int edn);
    chk({nm, " done_cyc"}, dn, edn);
    chk({nm, " nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({nm, " addr"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    int dn, edn, st, cnt, ic, ab, width;
    logic [2:0]  ia;
    logic [31:0] id, pat;
    logic [63:0] mask;

    Reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    core_data = '0; core_address = '0; core_byteena = '0;
    set_core(1'b0, 1'b0);
    next(); next(); next();
    @(negedge clk);
    chk("reset state", {busy, done_pulse, cur_idx}, '0);
    Reset = 1'b0;
    next();

    // Idle pass-through with arbitrary core traffic.
    for (int i = 0; i < 4; i++) begin
      set_core(1'b1, 1'b1);
      @(negedge clk);
      chk("idle pass", {mem_data, mem_address, mem_byteena, mem_wren, mem_rden},
          {core_data, core_address, core_byteena, core_wren, core_rden});
      next();
    end
    set_core(1'b0, 1'b0);

    // Reset values of START and PATTERN are used by a one-word fill.
    cfg_write(3'd1, 32'd1);
    cfg_write(3'd3, 32'd1);
    @(negedge clk);
    chk("reset regs fill", {mem_wren, mem_address, mem_data}, {1'b1, 32'd0, 32'd0});
    next();
    @(negedge clk);
    chk("reset regs done", {done_pulse, busy}, 2'b11);
    next();

    tbl[0]  = '{100,   3,  32'hFFFF_0000, 64'h0, -1, 3'd0, 32'd0, 3, 400,   404,   408, 0,   3};
    tbl[1]  = '{100,   3,  32'hFFFF_0000, 64'h2, -1, 3'd0, 32'd0, 3, 400,   404,   408, 0,   4};
    tbl[2]  = '{9598,  4,  32'h1234_5678, 64'h0, -1, 3'd0, 32'd0, 4, 38392, 38396, 0,   4,   4};
    tbl[3]  = '{55,    0,  32'hA5A5_A5A5, 64'h0, -1, 3'd0, 32'd0, 0, 0,     0,     0,   0,   0};
    tbl[4]  = '{100,   10, 32'hCAFE_F00D, 64'h0, 1,  3'd3, 32'd2, 1, 400,   0,     0,   0,   2};
    tbl[5]  = '{100,   10, 32'hCAFE_F00D, 64'h0, 1,  3'd3, 32'd3, 1, 400,   0,     0,   0,   2};
    tbl[6]  = '{10000, 2,  32'h0000_0001, 64'h0, -1, 3'd0, 32'd0, 2, 1600,  1604,  0,   0,   2};
    tbl[7]  = '{9599,  2,  32'h0000_0077, 64'h5, -1, 3'd0, 32'd0, 2, 38396, 0,     0,   0,   4};
    tbl[8]  = '{200,   4,  32'h1111_1111, 64'h0, 0,  3'd2, 32'h2222_2222, 4, 800, 804, 808, 812, 4};
    tbl[9]  = '{200,   4,  32'h1111_1111, 64'h0, 2,  3'd3, 32'd1, 4, 800,   804,   808, 812, 4};
    tbl[10] = '{200,   4,  32'h1111_1111, 64'h0, 1,  3'd0, 32'd5, 4, 800,   804,   808, 812, 4};

    foreach (tbl[i]) begin
      run_fill($sformatf("vec%0d", i), tbl[i].st, tbl[i].cnt, tbl[i].pat, tbl[i].mask, 1'b0,
               tbl[i].ic, tbl[i].ia, tbl[i].id, 0, dn);
      exp_q.delete();
      if (tbl[i].nw > 0) exp_q.push_back(32'(tbl[i].a0));
      if (tbl[i].nw > 1) exp_q.push_back(32'(tbl[i].a1));
      if (tbl[i].nw > 2) exp_q.push_back(32'(tbl[i].a2));
      if (tbl[i].nw > 3) exp_q.push_back(32'(tbl[i].a3));
      compare($sformatf("vec%0d", i), dn, tbl[i].dn);
    end

    // START written during the previous fill must not have taken effect.
    cfg_write(3'd3, 32'd1);
    @(negedge clk);
    chk("busy start write", {mem_wren, mem_address, mem_data}, {1'b1, 32'd800, 32'h1111_1111});
    next();
    for (int i = 0; i < 20 && busy; i++) next();
    @(negedge clk);
    chk("busy start end", busy, 1'b0);
    next();

    // Reset in the middle of a fill.
    cfg_write(3'd0, 32'd500);
    cfg_write(3'd1, 32'd20);
    cfg_write(3'd3, 32'd1);
    next(); next(); next();
    Reset = 1'b1;
    next();
    @(negedge clk);
    chk("midfill reset", {busy, done_pulse, cur_idx}, '0);
    next();
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post reset quiet", {mem_wren, busy, done_pulse}, 3'b000);
      next();
    end

`ifdef VGA_FILL_RECT_EN
    run_fill("rect", 0, 4, 32'h5A5A_5A5A, 64'h0, 1'b0, -1, 3'd0, 32'd0, 2, dn);
    exp_q.delete();
    exp_q.push_back(32'd0); exp_q.push_back(32'd4);
    exp_q.push_back(32'd320); exp_q.push_back(32'd324);
    compare("rect", dn, 4);
`endif

    for (int r = 0; r < 40; r++) begin
      st    = int'($urandom_range(0, 16383));
      cnt   = int'($urandom_range(0, 30));
      pat   = $urandom;
      mask  = {$urandom, $urandom} & {$urandom, $urandom};
      width = int'($urandom_range(0, ROW));
      ic = -1; ia = 3'd0; id = 32'd0;
      if (cnt > 0 && $urandom_range(0, 2) == 0) begin
        ic = int'($urandom_range(0, cnt + 5));
        case ($urandom_range(0, 3))
          0: begin ia = 3'd3; id = 32'd2; end
          1: begin ia = 3'd3; id = 32'd3; end
          2: begin ia = 3'd2; id = $urandom; end
          default: begin ia = 3'd3; id = 32'd1; end
        endcase
      end
      ab  = (ia == 3'd3 && id[1]) ? ic : -1;
      edn = model(st, cnt, mask, ab, width);
      run_fill($sformatf("rnd%0d", r), st, cnt, pat, mask, 1'b1, ic, ia, id, width, dn);
      compare($sformatf("rnd%0d", r), dn, edn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
